// File: rtl/ibis_triangle_scanner.sv
// Triangle scanner: walks the bounding box of a triangle in raster order and
// drives an external 10-phase edge finder, one edge test per ring revolution.
// A pixel whose three edge tests all pass becomes a fragment.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high; phase counter sits at 0
// BBOX  | one cycle: bounding box from the registered vertices, scan origin set
// SCAN  | edge finder running; pixel/edge stepping on each phase-9 result
module ibis_triangle_scanner #(
    parameter int WIDTH = 11
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] v0_x,
    input  logic [WIDTH-1:0] v0_y,
    input  logic [WIDTH-1:0] v1_x,
    input  logic [WIDTH-1:0] v1_y,
    input  logic [WIDTH-1:0] v2_x,
    input  logic [WIDTH-1:0] v2_y,
    output logic             frag_valid,
    input  logic             frag_ready,
    output logic [WIDTH-1:0] frag_x,
    output logic [WIDTH-1:0] frag_y,
    output logic             done,
    output logic             busy,
    output logic             ef_enable,
    output logic [5:0]       ef_write_locs,
    output logic [WIDTH-1:0] ef_a_x,
    output logic [WIDTH-1:0] ef_a_y,
    output logic [WIDTH-1:0] ef_b_x,
    output logic [WIDTH-1:0] ef_b_y,
    output logic [WIDTH-1:0] ef_c_x,
    output logic [WIDTH-1:0] ef_c_y,
    input  logic             ef_stencil_test,
    input  logic             ef_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BBOX = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [3:0]       phase;
    logic [1:0]       edge_idx;
    logic [WIDTH-1:0] r0_x, r0_y, r1_x, r1_y, r2_x, r2_y;
    logic [WIDTH-1:0] x, y, xmin, xmax, ymin, ymax;
    logic             stall, eval, pix_end, frag_load;

    function automatic logic [WIDTH-1:0] min3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [WIDTH-1:0] max3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

    // State register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state, handshake and edge-finder control. The ring only advances
    // while scanning, so SCAN always begins at phase 0 with no alignment wait.
    always_comb begin
        state_nxt     = state;
        cmd_ready     = 1'b0;
        busy          = 1'b0;
        ef_enable     = 1'b0;
        ef_write_locs = 6'h00;
        stall         = 1'b0;
        eval          = 1'b0;
        pix_end       = 1'b0;
        frag_load     = 1'b0;
        done          = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = BBOX;
            end
            BBOX: begin
                busy      = 1'b1;
                state_nxt = SCAN;
            end
            SCAN: begin
                busy          = 1'b1;
                stall         = (phase == 4'd9) && (edge_idx == 2'd2) && ef_stencil_test
                                && frag_valid && !frag_ready;
                ef_enable     = !stall;
                ef_write_locs = (phase == 4'd0) ? 6'h3F : 6'h00;
                eval          = (phase == 4'd9) && ef_enable && ef_ready;
                pix_end       = eval && (!ef_stencil_test || (edge_idx == 2'd2));
                frag_load     = eval && ef_stencil_test && (edge_idx == 2'd2);
                done          = pix_end && (x == xmax) && (y == ymax);
                if (done) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Edge operands: a/b walk the triangle edges, c is the current pixel.
    always_comb begin
        ef_c_x = x;
        ef_c_y = y;
        case (edge_idx)
            2'd0: begin
                ef_a_x = r0_x; ef_a_y = r0_y; ef_b_x = r1_x; ef_b_y = r1_y;
            end
            2'd1: begin
                ef_a_x = r1_x; ef_a_y = r1_y; ef_b_x = r2_x; ef_b_y = r2_y;
            end
            default: begin
                ef_a_x = r2_x; ef_a_y = r2_y; ef_b_x = r0_x; ef_b_y = r0_y;
            end
        endcase
    end

    // Vertex capture, bounding box, phase/edge/pixel stepping, fragment output.
    // End-of-row and end-of-box are detected by equality before incrementing,
    // so a box touching the top of the coordinate range never wraps.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r0_x <= '0; r0_y <= '0; r1_x <= '0; r1_y <= '0; r2_x <= '0; r2_y <= '0;
            xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
            x <= '0; y <= '0;
            phase      <= 4'd0;
            edge_idx   <= 2'd0;
            frag_valid <= 1'b0;
            frag_x     <= '0;
            frag_y     <= '0;
        end else begin
            if ((state == IDLE) && cmd_valid) begin
                r0_x <= v0_x; r0_y <= v0_y;
                r1_x <= v1_x; r1_y <= v1_y;
                r2_x <= v2_x; r2_y <= v2_y;
            end
            if (state == BBOX) begin
                xmin     <= min3(r0_x, r1_x, r2_x);
                xmax     <= max3(r0_x, r1_x, r2_x);
                ymin     <= min3(r0_y, r1_y, r2_y);
                ymax     <= max3(r0_y, r1_y, r2_y);
                x        <= min3(r0_x, r1_x, r2_x);
                y        <= min3(r0_y, r1_y, r2_y);
                edge_idx <= 2'd0;
            end
            if (ef_enable) phase <= (phase == 4'd9) ? 4'd0 : phase + 4'd1;
            if (eval) begin
                if (pix_end) begin
                    edge_idx <= 2'd0;
                    if (x == xmax) begin
                        if (y != ymax) begin
                            x <= xmin;
                            y <= y + 1'b1;
                        end
                    end else begin
                        x <= x + 1'b1;
                    end
                end else begin
                    edge_idx <= edge_idx + 2'd1;
                end
            end
            if (frag_load) begin
                frag_valid <= 1'b1;
                frag_x     <= x;
                frag_y     <= y;
            end else if (frag_valid && frag_ready) begin
                frag_valid <= 1'b0;
            end
        end
    end

endmodule
